serial_addsub_ctrl: RTL

SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

---
 rtl/serial_addsub_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract unit: one full-adder cell walks the operands LSB first,
// producing a WIDTH-bit result plus carry, signed-overflow and zero flags.
module serial_addsub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             sum_bit;
   logic             carry_nxt;

   // Returns {carry_out, sum}; subtraction inverts b and relies on carry-in of 1.
   function automatic logic [1:0] fa_cell(input logic ai, input logic bi,
                                          input logic sub, input logic ci);
      logic bb;
      bb = bi ^ sub;
      return {(ai & bb) | (ci & (ai ^ bb)), ai ^ bb ^ ci};
   endfunction

   always_comb begin
      {carry_nxt, sum_bit} = fa_cell(a_q[cnt_q], b_q[cnt_q], op_q, carry_q);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               op_d    = op;
               carry_d = op;
               cnt_d   = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            res_d[cnt_q] = sum_bit;
            carry_d      = carry_nxt;
            if (cnt_q == LAST) begin
               // Flags are committed together with the final result bit.
               state_d = S_DONE;
               cnt_d   = '0;
               cout_d  = carry_nxt;
               ovf_d   = carry_q ^ carry_nxt;
               zero_d  = (res_d == '0);
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         res_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         res_q   <= res_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   // Operand latches only matter once RUN is entered, so they carry no reset.
   always_ff @(posedge clk) begin
      a_q  <= a_d;
      b_q  <= b_d;
      op_q <= op_d;
   end

   assign busy      = (state_q == S_RUN);
   assign done      = (state_q == S_DONE);
   assign result    = res_q;
   assign carry_out = cout_q;
   assign overflow  = ovf_q;
   assign zero      = zero_q;

endmodule
